fpadd_seq_ctrl: RTL
===================

FPADD_SEQ_CTRL -- requirements
Module: fpadd_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ALIGN_SAT, default 25: the exponent difference at or above which the smaller operand is replaced by zero without shifting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports in_valid (input, 1), in_ready (output, 1): input handshake.
REQ-005 The block SHALL have ports Op_A and Op_B, input, 32 bits each: IEEE-754 single-precision operands.
REQ-006 The block SHALL have port Sub, input, 1 bit: 1 computes A-B, 0 computes A+B.
REQ-007 The block SHALL have ports out_valid (output, 1), out_ready (input, 1): output handshake.
REQ-008 The block SHALL have port Result, output, 32 bits: the FP32 result.
REQ-009 The block SHALL have port Overflow, output, 1 bit: the result saturated to infinity.
REQ-010 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, CMP, ALIGN, ADD, NORM and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; an operand is accepted on in_valid&in_ready, which captures Op_A, Op_B and Sub (B sign flipped if Sub=1) and moves to CMP.
REQ-013 Operand decode: an exponent of 0 SHALL be treated as zero (flush, mantissa 0); otherwise the 24-bit mantissa SHALL be {1, frac}; exponent 255 SHALL be treated as a normal value (no NaN/Inf handling).
REQ-014 CMP (1 cycle) SHALL compute the 9-bit exponent difference (borrow selects B as larger) and order the operands so that the larger exponent (ties broken by the larger mantissa) is the "big" operand.
REQ-015 CMP SHALL load the align counter with diff; if diff >= ALIGN_SAT it SHALL zero the small mantissa and go to ADD; if diff = 0 it SHALL go to ADD; otherwise it SHALL go to ALIGN.
REQ-016 ALIGN SHALL shift the small mantissa right by 1 bit per cycle and decrement the counter (discarded bits truncated), then go to ADD in the cycle after the counter reaches 0.
REQ-017 ADD (1 cycle) SHALL form a 25-bit sum; for equal signs it SHALL add the magnitudes, and for different signs it SHALL compute big minus small; the result sign SHALL be the big operand's sign.
REQ-018 NORM, if sum bit24 = 1, SHALL shift right 1 and add 1 to the exponent (1 cycle), then go to DONE.
REQ-019 NORM, if sum = 0, SHALL set the result to +0 (0x00000000) and go to DONE.
REQ-020 NORM, in the remaining cases, SHALL shift left 1 and subtract 1 from the exponent per cycle until bit23 = 1; if the exponent reaches 0 first, it SHALL flush the result to signed zero.
REQ-021 If the exponent becomes 255 after normalisation, Result SHALL be {sign, 0xFF, 0} and Overflow SHALL be 1.
REQ-022 In DONE, out_valid SHALL be 1 and Result and Overflow SHALL be held stable until out_ready=1, then the FSM SHALL return to IDLE.
REQ-023 A new input SHALL be accepted no earlier than the cycle after the out_valid&out_ready handshake.
REQ-024 Latency from acceptance to out_valid SHALL be 3 + min(diff, ALIGN_SAT-1 if diff<ALIGN_SAT else 0) + normalisation cycles; for zero-shift normalisation, NORM takes 1 cycle.
REQ-025 in_valid outside IDLE SHALL be ignored; operand inputs SHALL NOT affect an operation in progress.

Reset
REQ-026 While rst_n=0, asynchronously: state=IDLE, in_ready=1, out_valid=0, Busy=0, Result=0, Overflow=0, and all internal registers cleared.
REQ-027 Reset asserted in any state SHALL abort the operation with no output produced; after release, the first accepted operand SHALL be processed normally.

Verification
REQ-028 Op_A=0x3F800000 and Op_B=0x3F800000 with Sub=0 SHALL give Result=0x40000000 and Overflow=0, with out_valid 4 cycles after acceptance.
REQ-029 Op_A=0x3F800000 and Op_B=0x3F800000 with Sub=1 SHALL give Result=0x00000000.
REQ-030 Op_A=0x3F800000 and Op_B=0x30800000 (diff 30 >= ALIGN_SAT) SHALL give Result=0x3F800000 with no ALIGN cycles.
REQ-031 Op_A=0x40400000 (3.0) and Op_B=0x3F800000 with Sub=0 SHALL give Result=0x40800000 after 1 ALIGN cycle.
REQ-032 Op_A=Op_B=0x7F7FFFFF with Sub=0 SHALL give Result=0x7F800000 and Overflow=1.
REQ-033 Holding out_ready=0 for 5 cycles in DONE SHALL keep Result stable and in_ready=0; asserting rst_n=0 mid-ALIGN SHALL immediately give out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/fpadd_seq_ctrl_if.sv
// Handshake and data bundle for the sequential FP32 adder/subtractor.
// The master drives operands and out_ready; the slave is the adder.
interface fpadd_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Op_A;
    logic [31:0] Op_B;
    logic        Sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Overflow;
    logic        Busy;

    modport master (
        output in_valid, Op_A, Op_B, Sub, out_ready,
        input  in_ready, out_valid, Result, Overflow, Busy
    );

    modport slave (
        input  in_valid, Op_A, Op_B, Sub, out_ready,
        output in_ready, out_valid, Result, Overflow, Busy
    );
endinterface

// File: rtl/fpadd_seq_ctrl.sv
// Multi-cycle FP32 adder/subtractor: compare, bit-serial align, add, serial normalise.
// Denormals flush to zero on input; exponent 255 is treated as an ordinary value.
module fpadd_seq_ctrl #(
    parameter int ALIGN_SAT = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    fpadd_seq_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMP   = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [8:0] ALIGN_SAT_W = 9'(ALIGN_SAT);

    state_t      state_q,     state_d;
    logic        sign_a_q,    sign_a_d;
    logic        sign_b_q,    sign_b_d;
    logic [7:0]  exp_a_q,     exp_a_d;
    logic [7:0]  exp_b_q,     exp_b_d;
    logic [23:0] man_a_q,     man_a_d;
    logic [23:0] man_b_q,     man_b_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [24:0] sum_q,       sum_d;
    logic [8:0]  exp_q,       exp_d;
    logic        sign_q,      sign_d;
    logic [31:0] result_q,    result_d;
    logic        overflow_q,  overflow_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q,  in_ready_d;
    logic        busy_q,      busy_d;

    logic [8:0]  diff_s;
    logic        b_big_s;
    logic [7:0]  mag_s;

    // Zero exponent means zero (no denormals); otherwise restore the hidden one.
    function automatic logic [23:0] decode_man(input logic [31:0] op);
        if (op[30:23] == 8'd0) begin
            decode_man = 24'd0;
        end else begin
            decode_man = {1'b1, op[22:0]};
        end
    endfunction

    // Packs {overflow, result}; any exponent of 255 or above saturates to infinity.
    function automatic logic [32:0] pack_result(input logic       sign,
                                                input logic [8:0] exp9,
                                                input logic [22:0] frac);
        if (exp9 >= 9'd255) begin
            pack_result = {1'b1, sign, 8'hFF, 23'd0};
        end else begin
            pack_result = {1'b0, sign, exp9[7:0], frac};
        end
    endfunction

    // Borrow out of the 9-bit difference marks B as having the larger exponent.
    assign diff_s  = {1'b0, exp_a_q} - {1'b0, exp_b_q};
    assign b_big_s = diff_s[8] | ((diff_s == 9'd0) & (man_b_q > man_a_q));
    assign mag_s   = diff_s[8] ? (exp_b_q - exp_a_q) : diff_s[7:0];

    // Next-state and datapath for every stage of the operation.
    always_comb begin
        state_d     = state_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        man_a_d     = man_a_q;
        man_b_d     = man_b_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_a_d   = bus.Op_A[31];
                    sign_b_d   = bus.Op_B[31] ^ bus.Sub;
                    exp_a_d    = bus.Op_A[30:23];
                    exp_b_d    = bus.Op_B[30:23];
                    man_a_d    = decode_man(bus.Op_A);
                    man_b_d    = decode_man(bus.Op_B);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_CMP;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            // From here on operand A holds the big value and B the small one.
            S_CMP: begin
                if (b_big_s) begin
                    sign_a_d = sign_b_q;
                    sign_b_d = sign_a_q;
                    exp_a_d  = exp_b_q;
                    exp_b_d  = exp_a_q;
                    man_a_d  = man_b_q;
                    man_b_d  = man_a_q;
                end else begin
                    sign_a_d = sign_a_q;
                    sign_b_d = sign_b_q;
                end
                cnt_d = mag_s;
                if ({1'b0, mag_s} >= ALIGN_SAT_W) begin
                    man_b_d = 24'd0;
                    state_d = S_ADD;
                end else if (mag_s == 8'd0) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                man_b_d = man_b_q >> 1;
                cnt_d   = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_ALIGN;
                end
            end

            S_ADD: begin
                if (sign_a_q == sign_b_q) begin
                    sum_d = {1'b0, man_a_q} + {1'b0, man_b_q};
                end else begin
                    sum_d = {1'b0, man_a_q} - {1'b0, man_b_q};
                end
                exp_d   = {1'b0, exp_a_q};
                sign_d  = sign_a_q;
                state_d = S_NORM;
            end

            S_NORM: begin
                if (sum_q[24]) begin
                    {overflow_d, result_d} = pack_result(sign_q, exp_q + 9'd1, sum_q[23:1]);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (sum_q == 25'd0) begin
                    result_d    = 32'd0;
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (sum_q[23]) begin
                    {overflow_d, result_d} = pack_result(sign_q, exp_q, sum_q[22:0]);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    // Left shift one place; running out of exponent flushes to signed zero.
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 9'd1;
                    if (exp_q == 9'd1) begin
                        result_d    = {sign_q, 31'd0};
                        overflow_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d     = S_NORM;
                    end
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d     = S_DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            exp_a_q     <= 8'd0;
            exp_b_q     <= 8'd0;
            man_a_q     <= 24'd0;
            man_b_q     <= 24'd0;
            cnt_q       <= 8'd0;
            sum_q       <= 25'd0;
            exp_q       <= 9'd0;
            sign_q      <= 1'b0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            man_a_q     <= man_a_d;
            man_b_q     <= man_b_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Overflow  = overflow_q;
    assign bus.Busy      = busy_q;

endmodule
